// File: rtl/fft_input_loader_pkg.sv
// Shared FFT loader constants and state encoding; also used by the output unloader.
package fft_input_loader_pkg;
    localparam int FFT_DATA_W      = 16;
    localparam int FFT_BANK_ADDR_W = 9;
    localparam int FFT_N           = 4 * (1 << FFT_BANK_ADDR_W);

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_PAD,
        LD_START,
        LD_WAIT_BUSY,
        LD_WAIT_DONE
    } ld_state_t;
endpackage

// File: rtl/fft_input_loader_bank_addr_gen.sv
// fft_bank_addr_gen: maps linear sample index n to a one-hot bank write enable and bank address.
module fft_bank_addr_gen
    import fft_input_loader_pkg::*;
#(
    parameter int ADDR_W = FFT_BANK_ADDR_W
) (
    input  logic [ADDR_W+1:0] n,
    input  logic              en,
    output logic [3:0]        we,
    output logic [ADDR_W-1:0] addr
);
    assign addr = n[ADDR_W+1:2];

    for (genvar b = 0; b < 4; b++) begin : g_bank
        assign we[b] = en && (n[1:0] == 2'(b));
    end
endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: writes one N-point frame into the FFT core's RAM_A, pulses start, waits for done.
// Build option FFT_LOADER_ZEROPAD_EN: iLAST ends a short frame and the remaining slots are zero-filled.
module fft_input_loader
    import fft_input_loader_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int ADDR_W = FFT_BANK_ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic              iLAST,
    input  logic              iFFT_RDY,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    output logic              oBUSY,
    output logic [15:0]       oFRAME_CNT
);
    // N is a power of two, so the last index is all ones.
    localparam logic [ADDR_W+1:0] N_LAST = '1;

    ld_state_t         state;
    logic [ADDR_W+1:0] n;
    logic              start_dly;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        gen_we;
    logic [3:0]        we_q;
    logic [ADDR_W-1:0] gen_addr;
    logic [ADDR_W-1:0] addr_q;

    assign accept = iVALID && oREADY;

`ifdef FFT_LOADER_ZEROPAD_EN
    assign wr_en   = accept || (state == LD_PAD);
    assign wr_data = (state == LD_PAD) ? '0 : iDATA;
`else
    logic unused_last;
    assign unused_last = iLAST;
    assign wr_en       = accept;
    assign wr_data     = iDATA;
`endif

    fft_bank_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .n   (n),
        .en  (wr_en),
        .we  (gen_we),
        .addr(gen_addr)
    );

    assign {oWE_3, oWE_2, oWE_1, oWE_0} = we_q;
    assign oADDR_WR_0 = addr_q;
    assign oADDR_WR_1 = addr_q;
    assign oADDR_WR_2 = addr_q;
    assign oADDR_WR_3 = addr_q;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state      <= LD_IDLE;
            n          <= '0;
            start_dly  <= 1'b0;
            oREADY     <= 1'b0;
            oDATA      <= '0;
            addr_q     <= '0;
            we_q       <= '0;
            oSTART     <= 1'b0;
            oBUSY      <= 1'b0;
            oFRAME_CNT <= '0;
        end else begin
            we_q   <= gen_we;
            oSTART <= 1'b0;
            if (wr_en) begin
                addr_q <= gen_addr;
                oDATA  <= wr_data;
            end
            case (state)
                LD_IDLE: if (iFFT_RDY) begin
                    state  <= LD_LOAD;
                    oREADY <= 1'b1;
                end
                LD_LOAD: if (accept) begin
                    oBUSY <= 1'b1;
                    // n holds at N-1 so it only returns to 0 once the core is done.
                    if (n == N_LAST) begin
                        state  <= LD_START;
                        oREADY <= 1'b0;
`ifdef FFT_LOADER_ZEROPAD_EN
                    end else if (iLAST) begin
                        state  <= LD_PAD;
                        oREADY <= 1'b0;
                        n      <= n + 1'b1;
`endif
                    end else begin
                        n <= n + 1'b1;
                    end
                end
`ifdef FFT_LOADER_ZEROPAD_EN
                LD_PAD: begin
                    if (n == N_LAST) state <= LD_START;
                    else             n     <= n + 1'b1;
                end
`endif
                // One idle cycle lets the final RAM write land before the core starts.
                LD_START: begin
                    if (start_dly) begin
                        start_dly <= 1'b0;
                        oSTART    <= 1'b1;
                        state     <= LD_WAIT_BUSY;
                    end else begin
                        start_dly <= 1'b1;
                    end
                end
                LD_WAIT_BUSY: if (!iFFT_RDY) state <= LD_WAIT_DONE;
                LD_WAIT_DONE: if (iFFT_RDY) begin
                    oFRAME_CNT <= oFRAME_CNT + 16'd1;
                    n          <= '0;
                    oBUSY      <= 1'b0;
                    oREADY     <= 1'b1;
                    state      <= LD_LOAD;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: scoreboard of expected RAM writes plus directed sequences.
module tb_fft_input_loader;
    import fft_input_loader_pkg::*;

    localparam int DW = FFT_DATA_W;
    localparam int AW = FFT_BANK_ADDR_W;
    localparam int N  = FFT_N;

    logic          iCLK = 1'b0;
    logic          iRESET = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic          iVALID = 1'b0;
    logic          iLAST = 1'b0;
    logic          iFFT_RDY = 1'b1;
    logic          oREADY, oSTART, oBUSY;
    logic [DW-1:0] oDATA;
    logic [AW-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic          oWE_0, oWE_1, oWE_2, oWE_3;
    logic [15:0]   oFRAME_CNT;

    fft_input_loader dut (
        .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
        .iLAST(iLAST), .iFFT_RDY(iFFT_RDY), .oDATA(oDATA),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
        .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
        .oSTART(oSTART), .oBUSY(oBUSY), .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // Reference model: sample k of a frame must land in bank k%4 at address k/4.
    wr_t  wr_log[$];
    wr_t  pend;
    bit   pend_v = 0;
    bit   frame_full = 0;
    bit   padding = 0;
    bit   exp_start;
    int   m_n = 0;
    int   start_cd = 0;
    int   starts = 0;
    int   frames_exp = 0;
    logic [3:0] m_we;

    always @(negedge iCLK) begin
        m_we = {oWE_3, oWE_2, oWE_1, oWE_0};
        if (!iRESET) begin
            chk("reset_outputs", 32'({oREADY, oSTART, oBUSY, m_we, |oDATA, |oADDR_WR_0,
                                      |oADDR_WR_1, |oADDR_WR_2, |oADDR_WR_3, |oFRAME_CNT}), 32'd0);
            m_n = 0; pend_v = 0; start_cd = 0; frame_full = 0; padding = 0;
        end else begin
            if (pend_v) begin
                chk("wr_slot", 32'({m_we, oADDR_WR_0, oDATA}), 32'({pend.we, pend.addr, pend.data}));
                chk("wr_addr_all", 32'({oADDR_WR_1, oADDR_WR_2, oADDR_WR_3}), 32'({3{pend.addr}}));
                wr_log.push_back('{we: m_we, addr: oADDR_WR_0, data: oDATA});
            end else begin
                chk("wr_idle", 32'(m_we), 32'd0);
            end
            exp_start = 0;
            if (start_cd > 0) begin
                start_cd--;
                exp_start = (start_cd == 0);
            end
            chk("start_pulse", 32'(oSTART), 32'(exp_start));
            if (oSTART) starts++;
            if (frame_full) chk("ready_held_low", 32'(oREADY), 32'd0);

            pend_v = 0;
            if (padding) begin
                pend.we = 4'(1 << (m_n % 4)); pend.addr = AW'(m_n / 4); pend.data = '0;
                pend_v = 1;
                if (m_n == N - 1) begin padding = 0; m_n = 0; start_cd = 3; end
                else m_n++;
            end else if (iVALID && oREADY) begin
                pend.we = 4'(1 << (m_n % 4)); pend.addr = AW'(m_n / 4); pend.data = iDATA;
                pend_v = 1;
                if (m_n == N - 1) begin m_n = 0; start_cd = 3; frame_full = 1; end
`ifdef FFT_LOADER_ZEROPAD_EN
                else if (iLAST) begin m_n++; padding = 1; frame_full = 1; end
`endif
                else m_n++;
            end
        end
    end

    // vmode: 0 continuous, 1 toggling, 2 random valid. dmode: 0 data=index, 1 random data.
    task automatic send_frame(input int vmode, input int dmode, input int last_at, input int stop_at);
        int sent = 0;
        int guard = 0;
        bit pv = 0, pr = 0, ph = 0, done_f = 0;
        while (!done_f && guard < 20000) begin
            @(posedge iCLK); #1; guard++;
            if (pv && pr) begin
                sent++;
`ifdef FFT_LOADER_ZEROPAD_EN
                if (iLAST) done_f = 1;
`endif
                if (sent >= stop_at) done_f = 1;
            end
            if (!done_f) begin
                ph = ~ph;
                iVALID = (vmode == 0) ? 1'b1 : (vmode == 1) ? ph : 1'($urandom_range(0, 1));
                iDATA  = (dmode == 0) ? DW'(sent) : DW'($urandom);
                iLAST  = (sent == last_at);
                pv = iVALID; pr = oREADY;
            end
        end
        iVALID = 0; iLAST = 0;
        if (!done_f) chk("send_timeout", 32'(sent), 32'(stop_at));
    endtask

    // Core stand-in: on start, drop iFFT_RDY for 'hold' cycles, then report done.
    task automatic run_core(input int hold);
        int g = 0;
        while (!oSTART && g < 3000) begin @(negedge iCLK); g++; end
        chk("start_seen", 32'(oSTART), 32'd1);
        @(posedge iCLK); #1; iFFT_RDY = 0;
        repeat (hold) @(posedge iCLK);
        #1;
        chk("ready_during_core", 32'(oREADY), 32'd0);
        chk("busy_during_core", 32'(oBUSY), 32'd1);
        iFFT_RDY = 1; frame_full = 0;
        @(posedge iCLK); #1;
        frames_exp++;
        chk("frame_cnt", 32'(oFRAME_CNT), 32'(frames_exp));
        chk("busy_cleared", 32'(oBUSY), 32'd0);
        chk("ready_resumed", 32'(oREADY), 32'd1);
    endtask

    task automatic do_reset(input bit rdy);
        @(posedge iCLK); #1;
        iRESET = 0; iVALID = 0; iLAST = 0; iFFT_RDY = rdy;
        frames_exp = 0;
        repeat (3) @(posedge iCLK);
        #1; iRESET = 1;
    endtask

    typedef struct {
        int            idx;
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   bad;
        int   s0;
        tbl = '{'{0,    4'b0001, 9'd0,   16'd0},
                '{1,    4'b0010, 9'd0,   16'd1},
                '{4,    4'b0001, 9'd1,   16'd4},
                '{5,    4'b0010, 9'd1,   16'd5},
                '{6,    4'b0100, 9'd1,   16'd6},
                '{1026, 4'b0100, 9'd256, 16'd1026},
                '{2047, 4'b1000, 9'd511, 16'd2047}};

        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_state", 32'({oREADY, oSTART, oBUSY, oWE_0, oWE_1, oWE_2, oWE_3, |oFRAME_CNT}), 32'd0);
        iRESET = 1;

        // Continuous frame with data = index, long core run.
        wr_log.delete();
        send_frame(0, 0, -1, N);
        chk("ready_after_frame", 32'(oREADY), 32'd0);
        chk("busy_after_frame", 32'(oBUSY), 32'd1);
        run_core(100);
        chk("frame_a_count", 32'(wr_log.size()), 32'(N));
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].idx < wr_log.size()) begin
                chk($sformatf("tbl_we_%0d", tbl[i].idx), 32'(wr_log[tbl[i].idx].we), 32'(tbl[i].we));
                chk($sformatf("tbl_addr_%0d", tbl[i].idx), 32'(wr_log[tbl[i].idx].addr), 32'(tbl[i].addr));
                chk($sformatf("tbl_data_%0d", tbl[i].idx), 32'(wr_log[tbl[i].idx].data), 32'(tbl[i].data));
            end
        end

        // Toggling valid, random data: layout must still be contiguous per bank.
        wr_log.delete();
        send_frame(1, 1, -1, N);
        run_core(5);
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++)
            if (wr_log[i].we != 4'(1 << (i % 4)) || wr_log[i].addr != AW'(i / 4)) bad++;
        chk("toggle_count", 32'(wr_log.size()), 32'(N));
        chk("toggle_layout", 32'(bad), 32'd0);

        // Reset in the middle of a frame.
        s0 = starts;
        send_frame(2, 1, -1, 1000);
        iRESET = 0;
        #1;
        chk("async_reset_clear", 32'({oREADY, oBUSY, oWE_0, oWE_1, oWE_2, oWE_3, |oDATA, |oADDR_WR_0, |oFRAME_CNT}), 32'd0);
        frames_exp = 0;
        repeat (5) @(posedge iCLK);
        #1; iRESET = 1;
        repeat (10) @(posedge iCLK);
        #1;
        chk("no_start_after_abort", 32'(starts - s0), 32'd0);
        wr_log.delete();
        send_frame(0, 1, -1, N);
        run_core(3);
        chk("restart_first_slot", 32'({wr_log[0].we, wr_log[0].addr}), 32'({4'b0001, 9'd0}));

        // Core not ready at reset release: loader must stay idle.
        do_reset(0);
        repeat (5) @(posedge iCLK);
        #1;
        chk("idle_hold_ready", 32'(oREADY), 32'd0);
        iFFT_RDY = 1;
        @(posedge iCLK); #1;
        chk("idle_to_load", 32'(oREADY), 32'd1);

        // iLAST on sample 9.
        do_reset(1);
        wr_log.delete();
        send_frame(0, 0, 9, N);
        run_core(3);
        chk("last_frame_count", 32'(wr_log.size()), 32'(N));
        chk("last_data_9", 32'(wr_log[9].data), 32'd9);
`ifdef FFT_LOADER_ZEROPAD_EN
        chk("last_data_10", 32'(wr_log[10].data), 32'd0);
        chk("last_data_2047", 32'(wr_log[N-1].data), 32'd0);
`else
        chk("last_data_10", 32'(wr_log[10].data), 32'd10);
        chk("last_data_2047", 32'(wr_log[N-1].data), 32'd2047);
`endif

        // Three back-to-back frames.
        do_reset(1);
        s0 = starts;
        for (int f = 0; f < 3; f++) begin
            send_frame(2, 1, -1, N);
            chk("busy_in_frame", 32'(oBUSY), 32'd1);
            run_core($urandom_range(1, 20));
        end
        chk("three_frames", 32'(oFRAME_CNT), 32'd3);
        chk("three_starts", 32'(starts - s0), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
